// File: rtl/sram_like_slave.sv
// Responder end of an SRAM-like req/addr_ok/data_ok port in front of a 1-cycle RAM.
// Responses come back in order a fixed LATENCY after acceptance; ADDR_GAP and MAX_OUTSTANDING throttle acceptance.
module sram_like_slave #(
  parameter int LATENCY         = 2,
  parameter int ADDR_GAP        = 0,
  parameter int MAX_OUTSTANDING = 2,
  parameter int AW              = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req,
  input  logic          wr,
  input  logic [3:0]    wstrb,
  input  logic [2:0]    size,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          addr_ok,
  output logic          data_ok,
  output logic [31:0]   rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic [3:0]         gap_q, gap_d;
  logic [3:0]         inflight_q, inflight_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] wr_q, wr_d;
  logic               unused_bits;

  // Acceptance never looks at data_ok: a slot freed by a response is reusable only from the next cycle.
  assign addr_ok   = resetn && req && (gap_q == 4'd0) && (inflight_q < 4'(MAX_OUTSTANDING));
  assign mem_en    = addr_ok;
  assign mem_we    = (addr_ok && wr) ? wstrb : 4'b0000;
  assign mem_addr  = addr[AW+1:2];
  assign mem_wdata = wdata;
  assign data_ok   = vld_q[LATENCY-1];

  assign unused_bits = ^{size, addr[1:0], addr[31:AW+2]};

  always_comb begin
    vld_d    = vld_q;
    wr_d     = wr_q;
    vld_d[0] = addr_ok;
    wr_d[0]  = addr_ok && wr;
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      wr_d[k]  = wr_q[k-1];
    end

    gap_d = gap_q;
    if (addr_ok) begin
      gap_d = 4'(ADDR_GAP);
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    inflight_d = inflight_q + {3'b000, addr_ok} - {3'b000, data_ok};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap_q      <= 4'd0;
      inflight_q <= 4'd0;
      vld_q      <= '0;
      wr_q       <= '0;
    end else begin
      gap_q      <= gap_d;
      inflight_q <= inflight_d;
      vld_q      <= vld_d;
      wr_q       <= wr_d;
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      // The RAM output is already valid in the response cycle, so no capture stage exists.
      assign rdata = (data_ok && !wr_q[0]) ? mem_rdata : 32'd0;
    end else begin : g_latn
      logic [LATENCY-1:1][31:0] rd_q, rd_d;

      // Stage 2 samples the RAM in the cycle after the handshake; later stages just follow the valid bits.
      always_comb begin
        rd_d    = rd_q;
        rd_d[1] = mem_rdata;
        for (int k = 2; k < LATENCY; k++) begin
          rd_d[k] = rd_q[k-1];
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_d;
        end
      end

      assign rdata = (data_ok && !wr_q[LATENCY-1]) ? rd_q[LATENCY-1] : 32'd0;
    end
  endgenerate

endmodule

// File: tb/tb_sram_like_slave.sv
// Bench for sram_like_slave: five instances with different LATENCY/ADDR_GAP/MAX_OUTSTANDING,
// a transaction-level reference model checked every cycle, plus hand-computed directed checks.
`timescale 1ns/1ps
module tb_sram_like_slave;

  localparam int NI = 5;

  function automatic int lat_of(int i);
    case (i)
      0: return 2;
      1: return 2;
      2: return 4;
      3: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int gap_of(int i);
    return (i == 1) ? 2 : 0;
  endfunction

  function automatic int mo_of(int i);
    case (i)
      0: return 2;
      1: return 2;
      2: return 1;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] init_word(int i, int a);
    return 32'hA5000000 ^ 32'(i << 16) ^ 32'(a * 32'h0101);
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        req       [NI];
  logic        wr        [NI];
  logic [3:0]  wstrb     [NI];
  logic [2:0]  size      [NI];
  logic [31:0] addr      [NI];
  logic [31:0] wdata     [NI];
  logic        addr_ok   [NI];
  logic        data_ok   [NI];
  logic [31:0] rdata     [NI];
  logic        mem_en    [NI];
  logic [3:0]  mem_we    [NI];
  logic [15:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic [31:0] ram [256];
    logic [31:0] ram_rd;

    initial begin
      for (int k = 0; k < 256; k++) ram[k] = init_word(gi, k);
    end

    sram_like_slave #(
      .LATENCY(lat_of(gi)),
      .ADDR_GAP(gap_of(gi)),
      .MAX_OUTSTANDING(mo_of(gi)),
      .AW(16)
    ) u_dut (
      .clk(clk),
      .resetn(resetn),
      .req(req[gi]),
      .wr(wr[gi]),
      .wstrb(wstrb[gi]),
      .size(size[gi]),
      .addr(addr[gi]),
      .wdata(wdata[gi]),
      .addr_ok(addr_ok[gi]),
      .data_ok(data_ok[gi]),
      .rdata(rdata[gi]),
      .mem_en(mem_en[gi]),
      .mem_we(mem_we[gi]),
      .mem_addr(mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi])
    );

    // Read port returns junk unless a read was enabled, so a mistimed capture shows up.
    always @(posedge clk) begin
      ram_rd <= (mem_en[gi] && mem_we[gi] == 4'b0000) ? ram[mem_addr[gi][7:0]] : $urandom;
      if (mem_en[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[gi][b]) ram[mem_addr[gi][7:0]][8*b +: 8] = mem_wdata[gi][8*b +: 8];
        end
      end
    end
    assign mem_rdata[gi] = ram_rd;
  end

  typedef struct { int inst; int due; logic wr; logic [31:0] data; } rsp_t;
  typedef struct { int inst; int cyc; logic [31:0] data; } ev_t;

  rsp_t        pend [$];
  ev_t         hs_log [$];
  ev_t         rsp_log [$];
  int          last_hs [NI];
  logic [31:0] mdl_mem [NI][256];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d cyc=%0d got=%h want=%h", name, i, cyc, act, exp);
    end
  endtask

  // Model: every accepted request owes exactly one response lat cycles later; acceptance needs
  // the gap to have elapsed and fewer than the limit owed.
  always @(negedge clk) begin
    int          infl;
    bit          exp_aok;
    bit          exp_dok;
    logic [31:0] exp_rd;
    logic [3:0]  exp_we;
    for (int i = 0; i < NI; i++) begin
      if (req[i] && addr_ok[i]) hs_log.push_back('{i, cyc, addr[i]});
      if (data_ok[i]) rsp_log.push_back('{i, cyc, rdata[i]});
      if (!resetn) begin
        chk("rst_addr_ok", i, 32'(addr_ok[i]), 32'd0);
        chk("rst_data_ok", i, 32'(data_ok[i]), 32'd0);
        chk("rst_rdata", i, rdata[i], 32'd0);
        chk("rst_mem_en", i, 32'(mem_en[i]), 32'd0);
        chk("rst_mem_we", i, 32'(mem_we[i]), 32'd0);
      end else begin
        infl = 0;
        exp_dok = 1'b0;
        exp_rd = 32'd0;
        foreach (pend[k]) begin
          if (pend[k].inst == i) begin
            infl++;
            if (pend[k].due == cyc) begin
              exp_dok = 1'b1;
              exp_rd = pend[k].wr ? 32'd0 : pend[k].data;
            end
          end
        end
        exp_aok = req[i] && ((cyc - last_hs[i]) > gap_of(i)) && (infl < mo_of(i));
        exp_we = (exp_aok && wr[i]) ? wstrb[i] : 4'b0000;
        chk("addr_ok", i, 32'(addr_ok[i]), 32'(exp_aok));
        chk("mem_en", i, 32'(mem_en[i]), 32'(exp_aok));
        chk("mem_we", i, 32'(mem_we[i]), 32'(exp_we));
        chk("data_ok", i, 32'(data_ok[i]), 32'(exp_dok));
        chk("rdata", i, rdata[i], exp_rd);
        if (exp_aok) begin
          chk("mem_addr", i, 32'(mem_addr[i]), 32'(addr[i][17:2]));
          chk("mem_wdata", i, mem_wdata[i], wdata[i]);
          pend.push_back('{i, cyc + lat_of(i), wr[i], mdl_mem[i][addr[i][9:2]]});
          if (wr[i]) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[i][b]) mdl_mem[i][addr[i][9:2]][8*b +: 8] = wdata[i][8*b +: 8];
            end
          end
          last_hs[i] = cyc;
        end
      end
    end
    if (!resetn) begin
      pend.delete();
      for (int i = 0; i < NI; i++) last_hs[i] = -100;
    end else begin
      for (int k = pend.size() - 1; k >= 0; k--) begin
        if (pend[k].due <= cyc) pend.delete(k);
      end
    end
    cyc++;
  end

  function automatic int ev_cnt(bit rsp, int inst);
    int n = 0;
    if (rsp) begin
      foreach (rsp_log[k]) if (rsp_log[k].inst == inst) n++;
    end else begin
      foreach (hs_log[k]) if (hs_log[k].inst == inst) n++;
    end
    return n;
  endfunction

  function automatic ev_t ev_get(bit rsp, int inst, int n);
    ev_t e;
    int  m = 0;
    e = '{-1, -1, 32'hFFFF_FFFF};
    if (rsp) begin
      foreach (rsp_log[k]) if (rsp_log[k].inst == inst) begin if (m == n) e = rsp_log[k]; m++; end
    end else begin
      foreach (hs_log[k]) if (hs_log[k].inst == inst) begin if (m == n) e = hs_log[k]; m++; end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int i);
    req[i] = 1'b0; wr[i] = 1'b0; wstrb[i] = 4'h0; size[i] = 3'd2; addr[i] = 32'd0; wdata[i] = 32'd0;
  endtask

  task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int hc, output logic [3:0] we_seen);
    int n = 0;
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s; size[i] = 3'd2;
    #1;
    while (!addr_ok[i] && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL issue_timeout inst%0d cyc=%0d got=no_addr_ok want=addr_ok", i, cyc);
    end
    hc = cyc;
    we_seen = mem_we[i];
    step();
    idle(i);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, t1, base;
    logic [3:0]  we0, we1;
    ev_t         e;
    resetn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      idle(i);
      req[i] = 1'b1;
      last_hs[i] = -100;
      for (int k = 0; k < 256; k++) mdl_mem[i][k] = init_word(i, k);
    end

    // Reset holds every output low even with req asserted.
    repeat (3) step();
    for (int i = 0; i < NI; i++) begin
      chk("lit_rst_addr_ok", i, 32'(addr_ok[i]), 32'd0);
      chk("lit_rst_mem_en", i, 32'(mem_en[i]), 32'd0);
      idle(i);
    end
    step();
    resetn = 1'b1;
    repeat (3) step();
    chk("lit_idle_data_ok", 0, 32'(data_ok[0]), 32'd0);
    chk("lit_idle_addr_ok", 0, 32'(addr_ok[0]), 32'd0);

    // Write then read the same word on consecutive cycles.
    hs_log.delete(); rsp_log.delete();
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, t0, we0);
    issue(0, 1'b0, 32'h100, 32'h0, 4'h0, t1, we1);
    repeat (4) step();
    chk("lit_wr_mem_we", 0, 32'(we0), 32'h0000000F);
    chk("lit_rd_hs_offset", 0, 32'(t1 - t0), 32'd1);
    chk("lit_rsp_count", 0, 32'(ev_cnt(1'b1, 0)), 32'd2);
    e = ev_get(1'b1, 0, 0);
    chk("lit_wr_rsp_cyc", 0, 32'(e.cyc - t0), 32'd2);
    chk("lit_wr_rsp_rdata", 0, e.data, 32'd0);
    e = ev_get(1'b1, 0, 1);
    chk("lit_rd_rsp_cyc", 0, 32'(e.cyc - t0), 32'd3);
    chk("lit_rd_rsp_rdata", 0, e.data, 32'hDEADBEEF);

    // Byte-strobe merge.
    rsp_log.delete();
    issue(0, 1'b1, 32'h200, 32'h11223344, 4'hF, t0, we0);
    issue(0, 1'b1, 32'h200, 32'h0000AA00, 4'b0010, t1, we1);
    issue(0, 1'b0, 32'h200, 32'h0, 4'h0, t1, we1);
    repeat (4) step();
    chk("lit_strobe_rdata", 0, ev_get(1'b1, 0, 2).data, 32'h1122AA44);

    // ADDR_GAP=2 throttle with req held for 10 cycles.
    hs_log.delete();
    req[1] = 1'b1; addr[1] = 32'h10;
    base = cyc;
    repeat (10) step();
    idle(1);
    repeat (4) step();
    chk("lit_gap_hs_count", 1, 32'(ev_cnt(1'b0, 1)), 32'd4);
    for (int k = 0; k < 4; k++) chk("lit_gap_hs_cyc", 1, 32'(ev_get(1'b0, 1, k).cyc - base), 32'(3 * k));

    // LATENCY=4, one outstanding: next acceptance only after the response cycle.
    req[2] = 1'b1; addr[2] = 32'h20;
    base = cyc;
    repeat (11) step();
    idle(2);
    repeat (6) step();
    chk("lit_lim_hs_count", 2, 32'(ev_cnt(1'b0, 2)), 32'd3);
    for (int k = 0; k < 3; k++) chk("lit_lim_hs_cyc", 2, 32'(ev_get(1'b0, 2, k).cyc - base), 32'(5 * k));

    // LATENCY=1 combinational read path.
    rsp_log.delete();
    issue(3, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, t0, we0);
    issue(3, 1'b0, 32'h40, 32'h0, 4'h0, t1, we1);
    repeat (3) step();
    chk("lit_l1_hs_offset", 3, 32'(t1 - t0), 32'd2);
    e = ev_get(1'b1, 3, 1);
    chk("lit_l1_rsp_cyc", 3, 32'(e.cyc - t1), 32'd1);
    chk("lit_l1_rsp_rdata", 3, e.data, 32'hCAFEF00D);

    // Mixed traffic on every instance, checked by the model only.
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < NI; i++) begin
        req[i]   = ($urandom_range(0, 9) < 6);
        wr[i]    = 1'($urandom);
        wstrb[i] = 4'($urandom);
        size[i]  = 3'($urandom);
        addr[i]  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        wdata[i] = $urandom;
      end
      step();
    end
    for (int i = 0; i < NI; i++) idle(i);
    repeat (10) step();

    // Reset while two reads are in flight on the LATENCY=8 instance.
    issue(4, 1'b0, 32'h100, 32'h0, 4'h0, t0, we0);
    issue(4, 1'b0, 32'h104, 32'h0, 4'h0, t1, we1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    rsp_log.delete();
    repeat (9) step();
    chk("lit_rst_no_rsp", 4, 32'(ev_cnt(1'b1, 4)), 32'd0);
    req[4] = 1'b1; addr[4] = 32'h108;
    #1;
    chk("lit_rst_accept", 4, 32'(addr_ok[4]), 32'd1);
    step();
    idle(4);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
